// File: rtl/sam_sequencer_ctrl_pkg.sv
// Shared definitions for the SAM row sequencer controller: opcodes, compare
// result layout, default cell width and controller state encoding.
package sam_sequencer_ctrl_pkg;

    // Default width of one cell and of the broadcast target byte.
    localparam int CELL_SIZE = 8;

    // Command opcodes as they arrive on cmd_op.
    typedef enum logic [1:0] {
        OP_NOP    = 2'd0,
        OP_CFG    = 2'd1,
        OP_SCAN   = 2'd2,
        OP_INSERT = 2'd3
    } seq_op_e;

    // Compare result from the head of the cell chain, packed as {eq,gtr}.
    localparam int CMP_EQ_BIT  = 1;
    localparam int CMP_GTR_BIT = 0;

    typedef struct packed {
        logic eq;
        logic gtr;
    } compare_t;

    // Controller states.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CFG       = 3'd1,
        ST_SCAN_ARM  = 3'd2,
        ST_SCAN_WAIT = 3'd3,
        ST_INSERT    = 3'd4,
        ST_RESP      = 3'd5
    } seq_state_e;

endpackage

// File: rtl/sam_ins_mask_gen.sv
// Converts an insertion index into the per-cell strobe vectors: a one-hot
// insert point and a thermometer of cells above it that must shift up.
// Indices at or beyond NUM_CELLS produce empty vectors and flag an error.
module sam_ins_mask_gen #(
    parameter int NUM_CELLS = 32,
    parameter int IDX_W     = $clog2(NUM_CELLS)
) (
    input  logic [IDX_W:0]     idx,
    output logic [NUM_CELLS-1:0] ins_pt,
    output logic [NUM_CELLS-1:0] do_shift,
    output logic               out_of_range
);

    localparam logic [IDX_W:0] LIMIT = (IDX_W+1)'(NUM_CELLS);

    // Decode idx into one-hot insert point and thermometer shift mask.
    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves
        // a bit unassigned, which would otherwise infer a latch.
        ins_pt       = '0;
        do_shift     = '0;
        out_of_range = (idx >= LIMIT);
        for (int k = 0; k < NUM_CELLS; k++) begin
            if (!out_of_range) begin
                ins_pt[k]   = (idx == (IDX_W+1)'(k));
                do_shift[k] = ((IDX_W+1)'(k) > idx);
            end
        end
    end

endmodule

// File: rtl/sam_sequencer_ctrl.sv
// Row-level controller for a chain of SAM sequencer cells. Accepts one
// command (CFG, SCAN, INSERT, NOP) at a time, drives registered broadcast and
// per-cell strobes, samples the chain compare result for SCAN and returns a
// response over a valid/ready handshake. No command overlap.
module sam_sequencer_ctrl
    import sam_sequencer_ctrl_pkg::*;
#(
    parameter int NUM_CELLS = 32,
    parameter int CELL_SIZE = sam_sequencer_ctrl_pkg::CELL_SIZE,
    parameter int SCAN_LAT  = 4,
    parameter int IDX_W     = $clog2(NUM_CELLS)
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_op,
    input  logic [CELL_SIZE-1:0] cmd_target,
    input  logic [IDX_W:0]       cmd_idx,
    input  logic                 cmd_row_inx,
    output logic                 cell_cfg,
    output logic                 cell_is_scan,
    output logic                 cell_row_inx,
    output logic [CELL_SIZE-1:0] cell_target,
    output logic [NUM_CELLS-1:0] cell_ins_pt,
    output logic [NUM_CELLS-1:0] cell_do_shift,
    input  logic [1:0]           rslt_i,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [1:0]           rsp_rslt,
    output logic                 rsp_err
);

    seq_state_e             state;
    logic [3:0]             wait_cnt;
    logic                   idx_err;
    logic [NUM_CELLS-1:0]   mask_ins;
    logic [NUM_CELLS-1:0]   mask_shift;
    logic                   mask_oor;

    // Insert/shift masks are decoded straight from the incoming index so they
    // can be registered on the accept edge and appear in the INSERT cycle.
    sam_ins_mask_gen #(
        .NUM_CELLS (NUM_CELLS),
        .IDX_W     (IDX_W)
    ) u_mask_gen (
        .idx          (cmd_idx),
        .ins_pt       (mask_ins),
        .do_shift     (mask_shift),
        .out_of_range (mask_oor)
    );

    // Command FSM with all strobes and response fields registered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            cmd_ready     <= 1'b1;
            cell_cfg      <= 1'b0;
            cell_is_scan  <= 1'b0;
            cell_row_inx  <= 1'b0;
            cell_target   <= '0;
            cell_ins_pt   <= '0;
            cell_do_shift <= '0;
            wait_cnt      <= '0;
            idx_err       <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_rslt      <= '0;
            rsp_err       <= 1'b0;
        end else begin
            // NOTE: single-cycle strobes are cleared by default here and
            // re-asserted below; non-blocking semantics make the later
            // assignment win, so each strobe lasts exactly one cycle.
            cell_cfg      <= 1'b0;
            cell_is_scan  <= 1'b0;
            cell_ins_pt   <= '0;
            cell_do_shift <= '0;

            unique case (state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        cmd_ready    <= 1'b0;
                        cell_target  <= cmd_target;
                        cell_row_inx <= cmd_row_inx;
                        idx_err      <= mask_oor;
                        unique case (seq_op_e'(cmd_op))
                            OP_NOP: begin
                                rsp_valid <= 1'b1;
                                state     <= ST_RESP;
                            end
                            OP_CFG: begin
                                cell_cfg <= 1'b1;
                                state    <= ST_CFG;
                            end
                            OP_SCAN: begin
                                cell_is_scan <= 1'b1;
                                state        <= ST_SCAN_ARM;
                            end
                            OP_INSERT: begin
                                cell_ins_pt   <= mask_ins;
                                cell_do_shift <= mask_shift;
                                state         <= ST_INSERT;
                            end
                        endcase
                    end
                end

                ST_CFG: begin
                    rsp_valid <= 1'b1;
                    state     <= ST_RESP;
                end

                ST_SCAN_ARM: begin
                    wait_cnt <= 4'(SCAN_LAT - 1);
                    state    <= ST_SCAN_WAIT;
                end

                ST_SCAN_WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        rsp_rslt  <= rslt_i;
                        rsp_valid <= 1'b1;
                        state     <= ST_RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end

                ST_INSERT: begin
                    rsp_err   <= idx_err;
                    rsp_valid <= 1'b1;
                    state     <= ST_RESP;
                end

                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_rslt  <= '0;
                        rsp_err   <= 1'b0;
                        cmd_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end

                default: begin
                    cmd_ready <= 1'b1;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sam_sequencer_ctrl.sv
// Directed bench for sam_sequencer_ctrl (NUM_CELLS=32, SCAN_LAT=4): reset,
// CFG, NOP, SCAN timing, INSERT masks, back-to-back throughput, response
// backpressure and reset in the middle of a scan.
module tb_sam_sequencer_ctrl;

    localparam int NUM_CELLS = 32;
    localparam int CELL_SIZE = 8;
    localparam int SCAN_LAT  = 4;
    localparam int IDX_W     = 5;

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b0;
    logic                 cmd_valid = 1'b0;
    logic                 cmd_ready;
    logic [1:0]           cmd_op = 2'd0;
    logic [CELL_SIZE-1:0] cmd_target = '0;
    logic [IDX_W:0]       cmd_idx = '0;
    logic                 cmd_row_inx = 1'b0;
    logic                 cell_cfg;
    logic                 cell_is_scan;
    logic                 cell_row_inx;
    logic [CELL_SIZE-1:0] cell_target;
    logic [NUM_CELLS-1:0] cell_ins_pt;
    logic [NUM_CELLS-1:0] cell_do_shift;
    logic [1:0]           rslt_i = 2'b00;
    logic                 rsp_valid;
    logic                 rsp_ready = 1'b1;
    logic [1:0]           rsp_rslt;
    logic                 rsp_err;

    int n_cmp = 0;
    int n_bad = 0;

    sam_sequencer_ctrl #(
        .NUM_CELLS (NUM_CELLS),
        .CELL_SIZE (CELL_SIZE),
        .SCAN_LAT  (SCAN_LAT),
        .IDX_W     (IDX_W)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cmd_target    (cmd_target),
        .cmd_idx       (cmd_idx),
        .cmd_row_inx   (cmd_row_inx),
        .cell_cfg      (cell_cfg),
        .cell_is_scan  (cell_is_scan),
        .cell_row_inx  (cell_row_inx),
        .cell_target   (cell_target),
        .cell_ins_pt   (cell_ins_pt),
        .cell_do_shift (cell_do_shift),
        .rslt_i        (rslt_i),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_rslt      (rsp_rslt),
        .rsp_err       (rsp_err)
    );

    always #5 clk = ~clk;

    // Watchdog: the bench must never hang.
    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Present one command at a negedge, wait for the accept edge, then
    // scramble cmd_* so held values are really the registered ones.
    // Returns at the first negedge after the accept edge.
    task automatic send(input logic [1:0] op, input logic [7:0] target,
                        input logic [IDX_W:0] idx, input logic row);
        int t = 0;
        while (!cmd_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!cmd_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_wait cmd_ready=%b required 1", cmd_ready);
        end
        cmd_valid   = 1'b1;
        cmd_op      = op;
        cmd_target  = target;
        cmd_idx     = idx;
        cmd_row_inx = row;
        @(negedge clk);
        cmd_valid   = 1'b0;
        cmd_op      = 2'd0;
        cmd_target  = ~target;
        cmd_idx     = ~idx;
        cmd_row_inx = ~row;
    endtask

    task automatic test_reset();
        logic [79:0] obs;
        reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        obs = {cmd_ready, cell_cfg, cell_is_scan, cell_row_inx, cell_target,
               cell_ins_pt, cell_do_shift, rsp_valid, rsp_rslt, rsp_err};
        n_cmp++;
        if (obs !== {1'b1, 79'd0}) begin
            n_bad++;
            $display("FAIL reset_outputs got %h required %h", obs, {1'b1, 79'd0});
        end
        reset_n = 1'b1;
        @(negedge clk);
        obs = {cmd_ready, cell_cfg, cell_is_scan, cell_row_inx, cell_target,
               cell_ins_pt, cell_do_shift, rsp_valid, rsp_rslt, rsp_err};
        n_cmp++;
        if (obs !== {1'b1, 79'd0}) begin
            n_bad++;
            $display("FAIL reset_release got %h required %h", obs, {1'b1, 79'd0});
        end
    endtask

    task automatic test_cfg();
        logic [11:0] obs;
        rsp_ready = 1'b1;
        send(2'd1, 8'h33, '0, 1'b1);
        // accept+1: cfg strobe, target/row registered, ready low
        obs = {cell_cfg, rsp_valid, cmd_ready, cell_target, cell_row_inx};
        n_cmp++;
        if (obs !== {1'b1, 1'b0, 1'b0, 8'h33, 1'b1}) begin
            n_bad++;
            $display("FAIL cfg_strobe got %h required %h", obs, {1'b1, 1'b0, 1'b0, 8'h33, 1'b1});
        end
        @(negedge clk);
        // accept+2: response
        obs = {7'd0, cell_cfg, rsp_valid, rsp_rslt, rsp_err};
        n_cmp++;
        if (obs !== {7'd0, 1'b0, 1'b1, 2'b00, 1'b0}) begin
            n_bad++;
            $display("FAIL cfg_rsp got %h required %h", obs, {7'd0, 1'b0, 1'b1, 2'b00, 1'b0});
        end
        @(negedge clk);
        obs = {10'd0, rsp_valid, cmd_ready};
        n_cmp++;
        if (obs !== 12'b01) begin
            n_bad++;
            $display("FAIL cfg_done got %h required %h", obs, 12'b01);
        end
    endtask

    task automatic test_nop();
        logic [5:0] obs;
        rsp_ready = 1'b1;
        send(2'd0, 8'h11, '0, 1'b0);
        obs = {cell_cfg, cell_is_scan, rsp_valid, rsp_rslt, rsp_err};
        n_cmp++;
        if (obs !== 6'b001000) begin
            n_bad++;
            $display("FAIL nop_rsp got %b required %b", obs, 6'b001000);
        end
        @(negedge clk);
        obs = {4'd0, rsp_valid, cmd_ready};
        n_cmp++;
        if (obs !== 6'b000001) begin
            n_bad++;
            $display("FAIL nop_done got %b required %b", obs, 6'b000001);
        end
    endtask

    task automatic test_scan();
        logic [1:0]  obs2;
        logic [1:0]  exp2;
        logic [11:0] obs;
        rsp_ready = 1'b1;
        rslt_i    = 2'b01;
        send(2'd2, 8'h5A, '0, 1'b0);
        // cycles accept+1 .. accept+6; rslt_i is 10 only at the sample edge
        for (int c = 1; c <= 6; c++) begin
            rslt_i = (c == 5) ? 2'b10 : 2'b01;
            obs2 = {cell_is_scan, rsp_valid};
            exp2 = {(c == 1), (c == 6)};
            n_cmp++;
            if (obs2 !== exp2) begin
                n_bad++;
                $display("FAIL scan_cycle%0d {is_scan,rsp_valid} got %b required %b", c, obs2, exp2);
            end
            if (c < 6) @(negedge clk);
        end
        obs = {cell_target, cell_row_inx, rsp_rslt, rsp_err};
        n_cmp++;
        if (obs !== {8'h5A, 1'b0, 2'b10, 1'b0}) begin
            n_bad++;
            $display("FAIL scan_rsp got %h required %h", obs, {8'h5A, 1'b0, 2'b10, 1'b0});
        end
        @(negedge clk);
        rslt_i = 2'b00;
        obs = {cell_target, rsp_valid, cmd_ready, rsp_rslt};
        n_cmp++;
        if (obs !== {8'h5A, 1'b0, 1'b1, 2'b00}) begin
            n_bad++;
            $display("FAIL scan_done got %h required %h", obs, {8'h5A, 1'b0, 1'b1, 2'b00});
        end
    endtask

    task automatic test_insert();
        logic [IDX_W:0]       idx_tab   [5] = '{6'd5, 6'd31, 6'd32, 6'd0, 6'd63};
        logic [NUM_CELLS-1:0] ins_tab   [5] = '{32'h0000_0020, 32'h8000_0000, 32'h0,
                                                32'h0000_0001, 32'h0};
        logic [NUM_CELLS-1:0] shift_tab [5] = '{32'hFFFF_FFC0, 32'h0, 32'h0,
                                                32'hFFFF_FFFE, 32'h0};
        logic                 err_tab   [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [67:0] obs;
        logic [67:0] exp;
        rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send(2'd3, 8'hC3, idx_tab[i], 1'b1);
            obs = {cell_ins_pt, cell_do_shift, rsp_valid, 3'b000};
            exp = {ins_tab[i], shift_tab[i], 1'b0, 3'b000};
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL insert_masks idx=%0d got %h required %h", idx_tab[i], obs, exp);
            end
            @(negedge clk);
            obs = {cell_ins_pt, cell_do_shift, rsp_valid, rsp_rslt, rsp_err};
            exp = {32'h0, 32'h0, 1'b1, 2'b00, err_tab[i]};
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL insert_rsp idx=%0d got %h required %h", idx_tab[i], obs, exp);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        logic [1:0] obs;
        logic [1:0] exp;
        rsp_ready   = 1'b1;
        cmd_valid   = 1'b1;
        cmd_op      = 2'd1;
        cmd_target  = 8'h42;
        cmd_row_inx = 1'b0;
        // CFG latency 2 plus handshake: one accept every 3 cycles
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            obs = {cell_cfg, rsp_valid};
            exp = {(c % 3 == 1), (c % 3 == 2)};
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL b2b_cycle%0d {cfg,rsp_valid} got %b required %b", c, obs, exp);
            end
        end
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
    endtask

    task automatic test_backpressure();
        logic [2:0] obs;
        logic [9:0] obs10;
        rsp_ready = 1'b0;
        send(2'd1, 8'h10, '0, 1'b0);
        cmd_valid  = 1'b1;
        cmd_op     = 2'd2;
        cmd_target = 8'h77;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            obs = {rsp_valid, cmd_ready, cell_is_scan};
            n_cmp++;
            if (obs !== 3'b100) begin
                n_bad++;
                $display("FAIL bp_hold%0d {rsp_valid,cmd_ready,is_scan} got %b required %b", c, obs, 3'b100);
            end
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        obs = {rsp_valid, cmd_ready, cell_is_scan};
        n_cmp++;
        if (obs !== 3'b010) begin
            n_bad++;
            $display("FAIL bp_release got %b required %b", obs, 3'b010);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        obs10 = {cell_is_scan, cmd_ready, cell_target};
        n_cmp++;
        if (obs10 !== {1'b1, 1'b0, 8'h77}) begin
            n_bad++;
            $display("FAIL bp_scan_accept got %h required %h", obs10, {1'b1, 1'b0, 8'h77});
        end
        rslt_i = 2'b00;
        repeat (5) @(negedge clk);
        obs = {rsp_valid, rsp_rslt};
        n_cmp++;
        if (obs !== 3'b100) begin
            n_bad++;
            $display("FAIL bp_scan_rsp got %b required %b", obs, 3'b100);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_scan();
        logic [79:0] obs;
        logic [1:0]  obs2;
        rsp_ready = 1'b1;
        rslt_i    = 2'b11;
        send(2'd2, 8'hA5, '0, 1'b1);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        obs = {cmd_ready, cell_cfg, cell_is_scan, cell_row_inx, cell_target,
               cell_ins_pt, cell_do_shift, rsp_valid, rsp_rslt, rsp_err};
        n_cmp++;
        if (obs !== {1'b1, 79'd0}) begin
            n_bad++;
            $display("FAIL midscan_reset got %h required %h", obs, {1'b1, 79'd0});
        end
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            obs2 = {rsp_valid, cmd_ready};
            n_cmp++;
            if (obs2 !== 2'b01) begin
                n_bad++;
                $display("FAIL midscan_after%0d {rsp_valid,cmd_ready} got %b required %b", c, obs2, 2'b01);
            end
        end
        rslt_i = 2'b00;
    endtask

    initial begin
        test_reset();
        test_cfg();
        test_nop();
        test_scan();
        test_insert();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_scan();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
